// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: control codes and sequencer state encoding.
// Also used by the ALU and the main control unit.
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SRL  = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [2:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: (ALUop[2:0], funct, t0, t1) -> 3-bit code.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] alu_op_i,
  input  logic       funct_i,
  input  logic       t0_i,
  input  logic       t1_i,
  output logic [2:0] code_o
);

  always_comb begin
    code_o = ALU_ADD;
    if (alu_op_i[2]) begin
      code_o = {t1_i, t0_i, funct_i};
    end else begin
      unique case (alu_op_i[1:0])
        2'b00:   code_o = ALU_ADD;
        2'b01:   code_o = ALU_SUB;
        2'b10:   code_o = ALU_AND;
        default: code_o = ALU_OR;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequential ALU control: one decode request per handshake, registered control
// code held until the next accept, shifts run one bit per cycle under a counter.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int OPW   = 3,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] ALUop,
  input  logic           funct,
  input  logic           t0,
  input  logic           t1,
  input  logic [SW-1:0]  shamt,
  output logic [2:0]     ALUctrlbits,
  output logic           shift_en,
  output logic           out_valid,
  output logic           busy
);

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [2:0]      code_q, code_d;
  logic            shift_en_q, out_valid_q, busy_q;
  logic [2:0]      dec_code;
  logic            op_hi_unused;

  // Bits of ALUop above [2] carry no meaning here.
  assign op_hi_unused = ^ALUop;

  alu_ctrl_decode u_decode (
    .alu_op_i (ALUop[2:0]),
    .funct_i  (funct),
    .t0_i     (t0),
    .t1_i     (t1),
    .code_o   (dec_code)
  );

  assign in_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          code_d  = dec_code;
          state_d = DONE;
          if (is_shift(dec_code)) begin
            if (shamt != '0) begin
              cnt_d   = shamt;
              state_d = SHIFT;
            end else begin
              // A zero-length shift degenerates to a pass-through.
              code_d = ALU_PASS;
            end
          end
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      shift_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      shift_en_q  <= (state_d == SHIFT);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign ALUctrlbits = code_q;
  assign shift_en    = shift_en_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: directed requests with hand-computed codes.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] ALUop = '0;
  logic       funct = 1'b0, t0 = 1'b0, t1 = 1'b0;
  logic [2:0] shamt = '0;
  logic [2:0] ALUctrlbits;
  logic       shift_en, out_valid, busy;

  logic       in_valid16 = 1'b0;
  logic       in_ready16;
  logic [3:0] ALUop16 = '0;
  logic       funct16 = 1'b0, t0_16 = 1'b0, t1_16 = 1'b0;
  logic [3:0] shamt16 = '0;
  logic [2:0] code16;
  logic       shift_en16, out_valid16, busy16;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.WIDTH(8), .OPW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .funct(funct), .t0(t0), .t1(t1), .shamt(shamt),
    .ALUctrlbits(ALUctrlbits), .shift_en(shift_en), .out_valid(out_valid), .busy(busy)
  );

  alu_ctrl_seq #(.WIDTH(16), .OPW(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .ALUop(ALUop16), .funct(funct16), .t0(t0_16), .t1(t1_16), .shamt(shamt16),
    .ALUctrlbits(code16), .shift_en(shift_en16), .out_valid(out_valid16), .busy(busy16)
  );

  typedef struct {
    logic [2:0] code;
    int         shifts;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;

  // Model state, updated at each rising edge.
  int         cyc = 0, free_cyc = 0, sh_from = 1, sh_to = 0, ov_cyc = -1;
  logic [2:0] exp_code = '0;
  logic       rst_prev = 1'b0, started = 1'b0, accepted = 1'b0;
  logic [2:0] v_code = '0;
  int         v_shifts = 0;
  int         sh_run = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int e;
    e = cyc;
    rst_prev = rst;
    if (rst) begin
      started = 1'b1;
      sb.delete();
      free_cyc = e + 1;
      sh_from  = 1;
      sh_to    = 0;
      ov_cyc   = -1;
      exp_code = '0;
    end else if (started && in_valid && e >= free_cyc) begin
      sb.push_back('{code: v_code, shifts: v_shifts, acc: e});
      exp_code = v_code;
      sh_from  = e + 1;
      sh_to    = e + v_shifts;
      ov_cyc   = e + v_shifts + 1;
      free_cyc = e + v_shifts + 2;
      accepted = 1'b1;
    end
    cyc = e + 1;
  end

  always @(negedge clk) begin
    if (started) begin
      if (rst_prev) begin
        chk("rst_code", int'(ALUctrlbits), 0);
        chk("rst_shift_en", int'(shift_en), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        sh_run = 0;
      end else begin
        chk("code", int'(ALUctrlbits), int'(exp_code));
        chk("shift_en", int'(shift_en), int'(cyc >= sh_from && cyc <= sh_to));
        chk("out_valid", int'(out_valid), int'(cyc == ov_cyc));
        chk("busy", int'(busy), int'(cyc < free_cyc));
      end
      chk("in_ready", int'(in_ready), int'(!rst && cyc >= free_cyc));
      if (shift_en) sh_run++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out_valid", 1, 0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("sb_code", int'(ALUctrlbits), int'(x.code));
          chk("sb_latency", cyc - x.acc, x.shifts + 1);
          chk("sb_shift_count", sh_run, x.shifts);
        end
        sh_run = 0;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic f, input logic b0, input logic b1,
                      input logic [2:0] sh, input logic [2:0] code, input int shifts);
    int i;
    for (i = 0; i < 64 && cyc < free_cyc; i++) begin
      @(posedge clk); #1;
    end
    ALUop = op; funct = f; t0 = b0; t1 = b1; shamt = sh;
    v_code = code; v_shifts = shifts;
    accepted = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic poke(input int n);
    ALUop = 3'b000; funct = 1'b0; t0 = 1'b0; t1 = 1'b0; shamt = 3'd2;
    in_valid = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int nacc;
    logic p;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // R-type PASS code and non-R classes; upper ALUop bits of R-type ignored.
    send(3'b110, 1'b1, 1'b1, 1'b1, 3'd4, 3'b111, 0);
    send(3'b001, 1'b1, 1'b1, 1'b0, 3'd6, 3'b001, 0);
    send(3'b000, 1'b0, 1'b1, 1'b1, 3'd0, 3'b000, 0);
    send(3'b010, 1'b1, 1'b0, 1'b1, 3'd0, 3'b010, 0);
    send(3'b011, 1'b0, 1'b0, 1'b0, 3'd0, 3'b011, 0);
    send(3'b100, 1'b0, 1'b0, 1'b1, 3'd3, 3'b100, 0);
    send(3'b111, 1'b1, 1'b1, 1'b0, 3'd0, 3'b011, 0);

    // SLL by 5 with requests arriving during the shift.
    send(3'b100, 1'b1, 1'b0, 1'b1, 3'd5, 3'b101, 5);
    poke(3);

    // Shift boundaries: zero becomes PASS, then 3, 7 and 1.
    send(3'b100, 1'b0, 1'b1, 1'b1, 3'd0, 3'b111, 0);
    send(3'b100, 1'b0, 1'b1, 1'b1, 3'd3, 3'b110, 3);
    send(3'b100, 1'b1, 1'b0, 1'b1, 3'd7, 3'b101, 7);
    send(3'b100, 1'b1, 1'b0, 1'b1, 3'd1, 3'b101, 1);

    // Reset during the third shift cycle of an SLL by 7.
    send(3'b100, 1'b1, 1'b0, 1'b1, 3'd7, 3'b101, 7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    send(3'b001, 1'b0, 1'b0, 1'b0, 3'd0, 3'b001, 0);

    // Continuous in_valid alternating ADD / OR.
    for (int i = 0; i < 64 && cyc < free_cyc; i++) begin
      @(posedge clk); #1;
    end
    accepted = 1'b0;
    p = 1'b0;
    nacc = 0;
    ALUop = 3'b000; funct = 1'b1; t0 = 1'b1; t1 = 1'b0; shamt = 3'd3;
    v_code = 3'b000; v_shifts = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && nacc < 8; i++) begin
      @(posedge clk); #1;
      if (accepted) begin
        accepted = 1'b0;
        nacc++;
        p = ~p;
        ALUop  = p ? 3'b011 : 3'b000;
        v_code = p ? 3'b011 : 3'b000;
      end
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // WIDTH=16, OPW=4: SLL by 15 with the extra ALUop bit set.
    begin
      int n;
      int lat;
      logic seen;
      n = 0; lat = -1; seen = 1'b0;
      chk("w16_ready", int'(in_ready16), 1);
      ALUop16 = 4'b1101; funct16 = 1'b1; t0_16 = 1'b0; t1_16 = 1'b1; shamt16 = 4'd15;
      in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      chk("w16_code", int'(code16), 5);
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (shift_en16) n++;
        if (out_valid16) begin
          seen = 1'b1;
          lat = i;
        end
      end
      chk("w16_done_seen", int'(seen), 1);
      chk("w16_shift_count", n, 15);
      chk("w16_latency_index", lat, 15);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("w16_ready_after", int'(in_ready16), 1);
      chk("w16_busy_after", int'(busy16), 0);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
